pipe_buffer: RTL and testbench

Parametrised elastic buffer inserted between two pipeline stages. It carries the stage-to-stage valid/ready/flush handshake and a flat payload bus; the payload is the stage's output registers, concatenated. It generalises the single-entry stage register to DEPTH entries, adds an optional zero-latency fall-through mode and reports occupancy. This lets the slow units (dmem response, div, fpu) decouple from the stages upstream without stalling them.

---
 rtl/pipe_buffer_if.sv | 26 ++
 rtl/pipe_buffer.sv | 89 ++++++++
 tb/tb_pipe_buffer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/pipe_buffer_if.sv
// Stage-to-stage handshake bundle for pipe_buffer: valid/ready/flush, payload and occupancy.
// The slave modport is the buffer's view; the master modport is the surrounding stages' view.
interface pipe_buffer_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) ();
    logic                         valid_in;
    logic                         ready_out;
    logic                         flush_in;
    logic                         flush_out;
    logic [WIDTH-1:0]             data_in;
    logic                         valid_out;
    logic                         ready_in;
    logic [WIDTH-1:0]             data_out;
    logic [$clog2(DEPTH+1)-1:0]   level;

    modport slave (
        input  valid_in, flush_in, data_in, ready_in,
        output ready_out, flush_out, valid_out, data_out, level
    );

    modport master (
        output valid_in, flush_in, data_in, ready_in,
        input  ready_out, flush_out, valid_out, data_out, level
    );
endinterface

// File: rtl/pipe_buffer.sv
// Elastic DEPTH-entry buffer between two pipeline stages with optional zero-latency
// fall-through when empty; flush discards everything, reset overrides flush.
module pipe_buffer #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned FALLTHROUGH = 0
) (
    input  logic          clk,
    input  logic          reset,
    pipe_buffer_if.slave  bus
);
    localparam int unsigned CW   = $clog2(DEPTH + 1);
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam bit FT = (FALLTHROUGH != 0);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nxt;
    logic             w_empty;
    logic             w_ready;
    logic             w_valid;
    logic             w_bypass;
    logic             w_push;
    logic             w_pop;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign w_empty  = (r_count == '0);
    assign w_ready  = !reset && (r_count < FULL);
    assign w_valid  = FT ? (!w_empty || bus.valid_in) : !w_empty;
    assign w_bypass = FT && w_empty && bus.valid_in && bus.ready_in && !bus.flush_in;
    assign w_push   = bus.valid_in && w_ready && !bus.flush_in && !w_bypass;
    assign w_pop    = w_valid && bus.ready_in && !bus.flush_in && !w_bypass;

    assign bus.ready_out = w_ready;
    assign bus.flush_out = bus.flush_in;
    assign bus.valid_out = w_valid;
    assign bus.level     = r_count;

    // Empty storage is masked to zero so data_out is defined out of reset.
    always_comb begin
        bus.data_out = '0;
        if (reset) begin
            bus.data_out = '0;
        end else if (!w_empty) begin
            bus.data_out = r_mem[r_rd_ptr];
        end else if (FT) begin
            bus.data_out = bus.data_in;
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || bus.flush_in) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_count <= w_count_nxt;
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.data_in;
        end
    end
endmodule

// File: tb/tb_pipe_buffer.sv
// Directed bench for pipe_buffer: four instances cover reset, fill/drain, wrap streaming,
// full back-pressure, flush and fall-through.
module tb_pipe_buffer;
    logic clk = 1'b0;
    logic reset;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    pipe_buffer_if #(.WIDTH(32), .DEPTH(2)) if_d2 ();
    pipe_buffer_if #(.WIDTH(32), .DEPTH(3)) if_d3 ();
    pipe_buffer_if #(.WIDTH(32), .DEPTH(4)) if_d4 ();
    pipe_buffer_if #(.WIDTH(32), .DEPTH(2)) if_f2 ();

    pipe_buffer #(.WIDTH(32), .DEPTH(2), .FALLTHROUGH(0)) u_d2 (.clk(clk), .reset(reset), .bus(if_d2));
    pipe_buffer #(.WIDTH(32), .DEPTH(3), .FALLTHROUGH(0)) u_d3 (.clk(clk), .reset(reset), .bus(if_d3));
    pipe_buffer #(.WIDTH(32), .DEPTH(4), .FALLTHROUGH(0)) u_d4 (.clk(clk), .reset(reset), .bus(if_d4));
    pipe_buffer #(.WIDTH(32), .DEPTH(2), .FALLTHROUGH(1)) u_f2 (.clk(clk), .reset(reset), .bus(if_f2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled after settling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1;
        if_d2.valid_in = 0; if_d2.flush_in = 0; if_d2.data_in = 0; if_d2.ready_in = 0;
        if_d3.valid_in = 0; if_d3.flush_in = 0; if_d3.data_in = 0; if_d3.ready_in = 0;
        if_d4.valid_in = 0; if_d4.flush_in = 0; if_d4.data_in = 0; if_d4.ready_in = 0;
        if_f2.valid_in = 0; if_f2.flush_in = 0; if_f2.data_in = 0; if_f2.ready_in = 0;

        // 1. reset then idle
        tick();
        tick();
        chk("rst_ready_out", 32'(if_d2.ready_out), 32'd0);
        chk("rst_valid_out", 32'(if_d2.valid_out), 32'd0);
        chk("rst_level", 32'(if_d2.level), 32'd0);
        chk("rst_data_out", if_d2.data_out, 32'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_ready_out", 32'(if_d2.ready_out), 32'd1);
        chk("post_rst_valid_out", 32'(if_d2.valid_out), 32'd0);

        // 2. fill then drain, DEPTH=3
        if_d3.valid_in = 1;
        for (int i = 1; i <= 3; i++) begin
            if_d3.data_in = 32'hA000_0000 + 32'(i);
            tick();
            chk("fill_level", 32'(if_d3.level), 32'(i));
        end
        if_d3.valid_in = 0;
        chk("fill_ready_out_full", 32'(if_d3.ready_out), 32'd0);
        chk("fill_head", if_d3.data_out, 32'hA000_0001);
        if_d3.ready_in = 1;
        for (int i = 1; i <= 3; i++) begin
            settle();
            chk("drain_valid", 32'(if_d3.valid_out), 32'd1);
            chk("drain_data", if_d3.data_out, 32'hA000_0000 + 32'(i));
            tick();
            chk("drain_level", 32'(if_d3.level), 32'(3 - i));
        end
        chk("drain_valid_empty", 32'(if_d3.valid_out), 32'd0);

        // 3. streaming 0..9 through DEPTH=3 with pointer wrap
        if_d3.valid_in = 1;
        if_d3.data_in  = 0;
        settle();
        chk("stream_valid_c0", 32'(if_d3.valid_out), 32'd0);
        tick();
        for (int i = 1; i <= 10; i++) begin
            if_d3.valid_in = (i < 10);
            if_d3.data_in  = 32'(i);
            settle();
            chk("stream_valid", 32'(if_d3.valid_out), 32'd1);
            chk("stream_data", if_d3.data_out, 32'(i - 1));
            chk("stream_level", 32'(if_d3.level), 32'd1);
            tick();
        end
        chk("stream_end_level", 32'(if_d3.level), 32'd0);
        chk("stream_end_valid", 32'(if_d3.valid_out), 32'd0);
        if_d3.ready_in = 0;

        // 4. simultaneous push/pop attempt at full, DEPTH=2
        if_d2.valid_in = 1;
        if_d2.data_in  = 32'hB1;
        tick();
        if_d2.data_in  = 32'hB2;
        tick();
        chk("full_level", 32'(if_d2.level), 32'd2);
        chk("full_ready_out", 32'(if_d2.ready_out), 32'd0);
        if_d2.data_in  = 32'hB3;
        if_d2.ready_in = 1;
        settle();
        chk("full_pop_data", if_d2.data_out, 32'hB1);
        tick();
        chk("full_after_level", 32'(if_d2.level), 32'd1);
        chk("full_after_ready", 32'(if_d2.ready_out), 32'd1);
        chk("full_after_data", if_d2.data_out, 32'hB2);
        if_d2.valid_in = 0;
        tick();
        chk("full_b3_dropped_level", 32'(if_d2.level), 32'd0);
        chk("full_b3_dropped_valid", 32'(if_d2.valid_out), 32'd0);
        if_d2.ready_in = 0;

        // 5. flush with 3 stored entries and a payload on the input
        if_d4.valid_in = 1;
        for (int i = 1; i <= 3; i++) begin
            if_d4.data_in = 32'hC0 + 32'(i);
            tick();
        end
        chk("flush_pre_level", 32'(if_d4.level), 32'd3);
        if_d4.data_in  = 32'h55;
        if_d4.flush_in = 1;
        if_d4.ready_in = 1;
        settle();
        chk("flush_out_same_cycle", 32'(if_d4.flush_out), 32'd1);
        tick();
        if_d4.flush_in = 0;
        if_d4.valid_in = 0;
        settle();
        chk("flush_out_released", 32'(if_d4.flush_out), 32'd0);
        chk("flush_level", 32'(if_d4.level), 32'd0);
        chk("flush_valid", 32'(if_d4.valid_out), 32'd0);
        tick();
        chk("flush_no_55_valid", 32'(if_d4.valid_out), 32'd0);
        chk("flush_no_55_level", 32'(if_d4.level), 32'd0);

        // 6. fall-through, DEPTH=2
        if_f2.valid_in = 1;
        if_f2.data_in  = 32'h1234;
        if_f2.ready_in = 1;
        settle();
        chk("ft_bypass_valid", 32'(if_f2.valid_out), 32'd1);
        chk("ft_bypass_data", if_f2.data_out, 32'h1234);
        tick();
        chk("ft_bypass_level", 32'(if_f2.level), 32'd0);
        if_f2.ready_in = 0;
        tick();
        chk("ft_store_level", 32'(if_f2.level), 32'd1);
        if_f2.valid_in = 0;
        if_f2.data_in  = 32'hDEAD;
        settle();
        chk("ft_store_valid", 32'(if_f2.valid_out), 32'd1);
        chk("ft_store_data", if_f2.data_out, 32'h1234);
        if_f2.ready_in = 1;
        tick();
        chk("ft_drain_level", 32'(if_f2.level), 32'd0);
        chk("ft_drain_valid", 32'(if_f2.valid_out), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
